// File: rtl/sprite_pkg.sv
// ----------------------------------------------------------------------------
// sprite_pkg: shared constants, state encoding and default sprite positions.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package sprite_pkg;

  localparam int VACTIVE = 480;

  localparam logic [8:0] CTRL_ADDR   = 9'h100;
  localparam logic [8:0] STATUS_ADDR = 9'h101;
  localparam logic [8:0] FRAME_ADDR  = 9'h102;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Start positions for the stock sprites; values past 255 wrap into 8 bits.
  localparam logic [7:0] DINO_X     = 8'(100);
  localparam logic [7:0] DINO_Y     = 8'(100);
  localparam logic [7:0] JUMP_X     = 8'(200);
  localparam logic [7:0] JUMP_Y     = 8'(150);
  localparam logic [7:0] DUCK_X     = 8'(300);
  localparam logic [7:0] DUCK_Y     = 8'(200);
  localparam logic [7:0] CACTUS_X   = 8'(500);
  localparam logic [7:0] CACTUS_Y   = 8'(100);
  localparam logic [7:0] GODZILLA_X = 8'(100);
  localparam logic [7:0] GODZILLA_Y = 8'(260);

  localparam logic [16*8-1:0] SPRITE_RESET_VAL = {
    48'h0,
    GODZILLA_Y, GODZILLA_X,
    CACTUS_Y,   CACTUS_X,
    DUCK_Y,     DUCK_X,
    JUMP_Y,     JUMP_X,
    DINO_Y,     DINO_X
  };

endpackage

`default_nettype wire

// File: rtl/sprite_frame_sync.sv
// ----------------------------------------------------------------------------
// sprite_frame_sync: bus-writable shadow registers copied to the live set
// one register per cycle during vertical blank. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sprite_frame_sync #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 8,
  parameter int VACTIVE  = sprite_pkg::VACTIVE,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       chipselect,
  input  logic                       write,
  input  logic                       read,
  input  logic [8:0]                 address,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  input  logic [9:0]                 vcount,
  output logic [NUM_REGS*DATA_W-1:0] live_regs,
  output logic                       irq,
  output logic [15:0]                frame_count
);

  import sprite_pkg::*;

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [9:0]                 vcount_prev_q;
  logic [15:0]                frame_count_q;
  logic [NUM_REGS*DATA_W-1:0] shadow_q;
  logic [NUM_REGS*DATA_W-1:0] live_q;
  logic [31:0]                readdata_q;
  logic [31:0]                readdata_d;
  logic                       auto_q;
  logic                       pending_q;
  logic                       irq_q;
  logic [IDX_W-1:0]           idx_q;
  state_e                     state_q;

  logic vblank_start;
  logic bus_wr;
  logic bus_rd;
  logic shadow_hit;
  logic ctrl_wr;
  logic go;
  logic irq_clr;
  logic busy;

  assign vblank_start = (vcount == 10'(VACTIVE)) && (vcount_prev_q != 10'(VACTIVE));
  assign bus_wr       = chipselect && write;
  assign bus_rd       = chipselect && read;
  assign shadow_hit   = (address < 9'(NUM_REGS));
  assign ctrl_wr      = bus_wr && (address == CTRL_ADDR);
  assign go           = ctrl_wr && writedata[0];
  assign irq_clr      = bus_wr && (address == STATUS_ADDR) && writedata[1];
  assign busy         = (state_q == COMMIT);

  logic unused_ok;
  assign unused_ok = ^writedata[31:DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vcount_prev_q <= '0;
      frame_count_q <= '0;
    end else begin
      vcount_prev_q <= vcount;
      if (vblank_start) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  always_comb begin
    readdata_d = '0;
    if (shadow_hit) begin
      readdata_d = 32'(shadow_q[address[IDX_W-1:0]*DATA_W +: DATA_W]);
    end else begin
      case (address)
        CTRL_ADDR:   readdata_d = {30'd0, auto_q, 1'b0};
        STATUS_ADDR: readdata_d = {29'd0, busy, irq_q, pending_q};
        FRAME_ADDR:  readdata_d = {16'd0, frame_count_q};
        default:     readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q   <= RESET_VAL;
      auto_q     <= 1'b0;
      readdata_q <= '0;
    end else begin
      if (bus_wr && shadow_hit) begin
        shadow_q[address[IDX_W-1:0]*DATA_W +: DATA_W] <= writedata[DATA_W-1:0];
      end
      if (ctrl_wr) begin
        auto_q <= writedata[1];
      end
      if (bus_rd) begin
        readdata_q <= readdata_d;
      end
    end
  end

  // The irq clear is placed before the set so that a same-cycle set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
      live_q    <= RESET_VAL;
    end else begin
      if (irq_clr) begin
        irq_q <= 1'b0;
      end
      if (go) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        IDLE, ARMED: begin
          if (vblank_start && (pending_q || auto_q)) begin
            state_q   <= COMMIT;
            idx_q     <= '0;
            pending_q <= go;
          end else if (go) begin
            state_q <= ARMED;
          end
        end
        COMMIT: begin
          // Copy reads the shadow as it stands this cycle, so bus writes to
          // indices not yet reached still make it into this frame.
          live_q[idx_q*DATA_W +: DATA_W] <= shadow_q[idx_q*DATA_W +: DATA_W];
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            irq_q   <= 1'b1;
            state_q <= (pending_q || go) ? ARMED : IDLE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign readdata    = readdata_q;
  assign live_regs   = live_q;
  assign irq         = irq_q;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_frame_sync.sv
// ----------------------------------------------------------------------------
// tb_sprite_frame_sync: directed stimulus with a cycle-stamped scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_frame_sync;

  import sprite_pkg::*;

  localparam int NR = 16;
  localparam logic [127:0] DEF = 128'h0000_0000_0000_0464_64F4_C82C_96C8_6464;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          chipselect = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [8:0]    address = '0;
  logic [31:0]   writedata = '0;
  logic [9:0]    vcount = '0;
  logic [31:0]   readdata;
  logic [NR*8-1:0] live_regs;
  logic          irq;
  logic [15:0]   frame_count;

  sprite_frame_sync #(
    .NUM_REGS (NR),
    .DATA_W   (8),
    .VACTIVE  (480),
    .RESET_VAL(SPRITE_RESET_VAL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .vcount     (vcount),
    .live_regs  (live_regs),
    .irq        (irq),
    .frame_count(frame_count)
  );

  always #10 clk = ~clk;

  typedef enum int {K_RD, K_LIVE, K_LIVEALL, K_IRQ, K_FC} kind_e;
  typedef struct {
    int           cyc;
    kind_e        kind;
    int           idx;
    logic [127:0] exp;
    string        name;
  } exp_t;

  exp_t exq[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [127:0] mon_act;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = exq.size() - 1; i >= 0; i--) begin
      if (exq[i].cyc <= cyc) begin
        case (exq[i].kind)
          K_RD:      mon_act = 128'(readdata);
          K_LIVE:    mon_act = 128'(live_regs[exq[i].idx*8 +: 8]);
          K_LIVEALL: mon_act = 128'(live_regs);
          K_IRQ:     mon_act = 128'(irq);
          default:   mon_act = 128'(frame_count);
        endcase
        n_total++;
        if (exq[i].cyc < cyc)
          $display("FAIL %s: check missed, required at cycle %0d, now %0d",
                   exq[i].name, exq[i].cyc, cyc);
        else if (mon_act === exq[i].exp)
          n_pass++;
        else
          $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
                   exq[i].name, mon_act, exq[i].exp, cyc);
        exq.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_at(input int c, input kind_e k, input int idx,
                           input logic [127:0] e, input string nm);
    exp_t x;
    x.cyc = c; x.kind = k; x.idx = idx; x.exp = e; x.name = nm;
    exq.push_back(x);
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [8:0] a, input logic [31:0] e, input string nm);
    chipselect = 1'b1; read = 1'b1; address = a;
    expect_at(cyc + 1, K_RD, 0, 128'(e), nm);
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic start_frame(output int t0);
    vcount = 10'd480;
    t0 = cyc;
    tick();
    vcount = 10'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int t1;
    logic [7:0] prev5;
    logic [7:0] val;

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state and default sprite constants
    expect_at(cyc, K_LIVEALL, 0, DEF, "reset_live");
    expect_at(cyc, K_IRQ, 0, 128'd0, "reset_irq");
    expect_at(cyc, K_FC, 0, 128'd0, "reset_frame_count");
    expect_at(cyc, K_RD, 0, 128'd0, "reset_readdata");
    bus_read(9'd3, 32'h96, "rd_reg3");
    bus_read(FRAME_ADDR, 32'h0, "rd_frame0");
    bus_read(STATUS_ADDR, 32'h0, "rd_status0");
    bus_read(9'd4, 32'h2C, "rd_reg4_duck_x");
    bus_read(9'd6, 32'hF4, "rd_reg6_cactus_x");
    bus_read(9'd9, 32'h04, "rd_reg9_godzilla_y");

    // Shadow write without a commit request leaves live untouched
    bus_write(9'd0, 32'hFFFF_FF55);
    bus_read(9'd0, 32'h55, "rd_shadow0");
    start_frame(t0);
    expect_at(t0 + 1, K_FC, 0, 128'd1, "noctrl_frame_count");
    expect_at(t0 + 4, K_LIVE, 0, 128'h64, "noctrl_live0");
    expect_at(t0 + 20, K_IRQ, 0, 128'd0, "noctrl_irq");
    wait_until(t0 + 25);
    bus_read(STATUS_ADDR, 32'h0, "noctrl_status");

    // Requested commit: timing of first/last copy and irq
    bus_write(9'd15, 32'hAA);
    bus_write(CTRL_ADDR, 32'h1);
    bus_read(STATUS_ADDR, 32'h1, "armed_status");
    start_frame(t0);
    expect_at(t0 + 1, K_FC, 0, 128'd2, "commit_frame_count");
    expect_at(t0 + 1, K_LIVE, 0, 128'h64, "commit_live0_before");
    expect_at(t0 + 2, K_LIVE, 0, 128'h55, "commit_live0_after");
    expect_at(t0 + 16, K_LIVE, 15, 128'h00, "commit_live15_before");
    expect_at(t0 + 17, K_LIVE, 15, 128'hAA, "commit_live15_after");
    expect_at(t0 + 16, K_IRQ, 0, 128'd0, "commit_irq_before");
    expect_at(t0 + 17, K_IRQ, 0, 128'd1, "commit_irq_set_wins");
    wait_until(t0 + 3);
    bus_read(STATUS_ADDR, 32'h4, "commit_status_busy");
    wait_until(t0 + 16);
    bus_write(STATUS_ADDR, 32'h2);
    bus_read(STATUS_ADDR, 32'h2, "commit_status_done");
    bus_write(STATUS_ADDR, 32'h2);
    expect_at(cyc, K_IRQ, 0, 128'd0, "irq_cleared");
    bus_read(STATUS_ADDR, 32'h0, "status_after_clear");

    // Auto mode follows reg5 each frame without CTRL bit0 writes
    bus_write(CTRL_ADDR, 32'h2);
    bus_read(CTRL_ADDR, 32'h2, "ctrl_auto");
    prev5 = 8'hC8;
    for (int f = 0; f < 2; f++) begin
      val = (f == 0) ? 8'h11 : 8'h22;
      bus_write(9'd5, 32'(val));
      start_frame(t0);
      expect_at(t0 + 1, K_FC, 0, 128'(3 + f), "auto_frame_count");
      expect_at(t0 + 6, K_LIVE, 5, 128'(prev5), "auto_live5_before");
      expect_at(t0 + 7, K_LIVE, 5, 128'(val), "auto_live5_after");
      wait_until(t0 + 20);
      bus_read(STATUS_ADDR, 32'h2, "auto_status");
      prev5 = val;
    end
    bus_write(CTRL_ADDR, 32'h0);
    bus_write(STATUS_ADDR, 32'h2);

    // Writes during COMMIT: late index lands this frame, re-arm applies next frame
    bus_write(CTRL_ADDR, 32'h1);
    start_frame(t0);
    expect_at(t0 + 1, K_FC, 0, 128'd5, "rearm_frame_count");
    expect_at(t0 + 11, K_LIVE, 10, 128'h00, "midcommit_live10_before");
    expect_at(t0 + 12, K_LIVE, 10, 128'h11, "midcommit_live10_after");
    expect_at(t0 + 17, K_IRQ, 0, 128'd1, "midcommit_irq");
    wait_until(t0 + 3);
    bus_write(9'd10, 32'h11);
    bus_write(CTRL_ADDR, 32'h1);
    wait_until(t0 + 17);
    bus_read(STATUS_ADDR, 32'h3, "rearm_status_armed");
    wait_until(t0 + 25);
    bus_write(9'd10, 32'h33);
    start_frame(t1);
    expect_at(t1 + 1, K_FC, 0, 128'd6, "rearm2_frame_count");
    expect_at(t1 + 11, K_LIVE, 10, 128'h11, "rearm2_live10_before");
    expect_at(t1 + 12, K_LIVE, 10, 128'h33, "rearm2_live10_after");
    wait_until(t1 + 20);
    bus_read(STATUS_ADDR, 32'h2, "rearm2_status");

    // Reset in the middle of a commit
    bus_write(9'd1, 32'h77);
    bus_write(CTRL_ADDR, 32'h1);
    start_frame(t0);
    expect_at(t0 + 3, K_LIVE, 1, 128'h77, "abort_live1_copied");
    wait_until(t0 + 5);
    reset = 1'b1;
    expect_at(cyc, K_LIVEALL, 0, DEF, "abort_live_reset");
    expect_at(cyc, K_IRQ, 0, 128'd0, "abort_irq_reset");
    expect_at(cyc, K_FC, 0, 128'd0, "abort_frame_count_reset");
    tick();
    tick();
    reset = 1'b0;
    bus_read(STATUS_ADDR, 32'h0, "abort_status_idle");
    bus_read(9'd1, 32'h64, "abort_shadow1_reset");
    bus_write(FRAME_ADDR, 32'h1234);
    bus_write(9'h1FF, 32'hFFFF_FFFF);
    bus_read(9'h1FF, 32'h0, "rd_unmapped");
    bus_read(FRAME_ADDR, 32'h0, "rd_frame_ro");
    bus_write(9'd16, 32'h5A);
    bus_read(9'd16, 32'h0, "rd_beyond_regs");
    bus_read(9'd15, 32'h0, "rd_reg15_untouched");
    bus_read(STATUS_ADDR, 32'h0, "status_after_junk_writes");
    start_frame(t0);
    expect_at(t0 + 1, K_FC, 0, 128'd1, "post_reset_frame_count");
    expect_at(t0 + 20, K_LIVEALL, 0, DEF, "post_reset_live_idle");
    wait_until(t0 + 24);

    repeat (4) tick();
    foreach (exq[i]) begin
      n_total++;
      $display("FAIL %s: never checked (required cycle %0d)", exq[i].name, exq[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_frame_sync.md
# sprite_frame_sync

Frame-synchronous configuration controller for the sprite renderer. Holds a bus-writable shadow copy of all sprite position/score registers and copies it into the live register set feeding the pixel pipeline only during vertical blank, so software updates never tear a frame. Sits between the Avalon-style slave port and the sprite compositor. Counts frames and raises a commit-done interrupt.

## Interface
- NUM_REGS, 16: number of 8-bit sprite registers; legal range 2–64.
- DATA_W, 8: register width.
- VACTIVE, 480: first vcount value of vertical blank.
- RESET_VAL, all-zero (NUM_REGS*DATA_W bits): per-register reset value; register i occupies bits [i*DATA_W +: DATA_W].
- clk  in  1  pixel-domain clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- chipselect  in  1  bus select.
- write  in  1  bus write strobe.
- read  in  1  bus read strobe.
- address  in  9  word address.
- writedata  in  32  bus write data.
- readdata  out  32  registered read data.
- vcount  in  10  current line from the VGA timing counters.
- live_regs  out  NUM_REGS*DATA_W  committed registers to the compositor.
- irq  out  1  commit-done interrupt, level, sticky.
- frame_count  out  16  vertical blanks seen since reset, wraps.

## Operation
- Address map:
  - 0..NUM_REGS-1 = shadow register i. A write stores writedata[DATA_W-1:0]; a read returns the shadow value zero-extended.
  - 0x100 CTRL: bit0 write-1 sets pending; bit1 = auto mode (R/W).
  - 0x101 STATUS: bit0 pending, bit1 irq, bit2 busy (state COMMIT). Writing 1 to bit1 clears irq.
  - 0x102 = frame_count.
  - Other addresses: writes ignored, reads return 0.
- vblank_start is asserted when vcount == VACTIVE and the registered previous vcount != VACTIVE, i.e. once per frame.
- frame_count increments on every vblank_start, 0xFFFF -> 0x0000.
- FSM states are IDLE, ARMED and COMMIT.
  - IDLE -> ARMED on a CTRL bit0 write.
  - IDLE or ARMED -> COMMIT on vblank_start if pending or auto mode is set; pending clears on entry.
  - ARMED stays ARMED until vblank_start.
  - COMMIT copies shadow[idx] to live[idx], one register per cycle, idx = 0..NUM_REGS-1.
  - After the last copy: COMMIT -> IDLE and irq is set.
- Bus writes to shadow are always accepted, including during COMMIT. Each copy uses the shadow value present in its cycle, so a write to a not-yet-copied index lands in this frame.
- A CTRL bit0 write during COMMIT sets pending again; the FSM goes to ARMED after COMMIT and applies that request at the next frame.
- An irq-clear write in the same cycle as irq set: set wins.
- Reset mid-COMMIT aborts the copy. live_regs and shadow both return to RESET_VAL.

## Timing
- Reset values:
  - live_regs = shadow = RESET_VAL.
  - readdata = 0, irq = 0, frame_count = 0.
  - pending = 0, auto = 0, idx = 0, state IDLE.
- Read latency is 1 cycle: readdata is valid the cycle after chipselect && read and holds until the next read.
- Write effect is visible in register/STATUS reads the next cycle.
- Let cycle 0 be the first cycle with vcount == VACTIVE.
  - frame_count updates at cycle 1.
  - The state is COMMIT from cycle 1.
  - live register i changes at cycle 2+i.
  - irq is high and the state is IDLE/ARMED at cycle NUM_REGS+1.
- A commit (NUM_REGS+1 cycles) always fits in vertical blank (45 lines × 1600 cycles).
- live_regs never changes outside COMMIT or reset.

## Structure
- Package sprite_pkg holds:
  - VACTIVE, and the CTRL/STATUS/FRAME addresses (0x100/0x101/0x102).
  - The state enum {IDLE, ARMED, COMMIT}.
  - The default sprite RESET_VAL constants: dino 100/100, jump 200/150, duck 300/200, cactus 500/100 truncated to 8 bits, godzilla 100/260 truncated to 8 bits.
- Single module; no sub-module. Edge detect, FSM, register file and read mux are inline.

## Test plan
- Reset, then read reg 3 and frame_count -> readdata = RESET_VAL[3], 0; live_regs = RESET_VAL; irq = 0.
- Write reg0 = 0x55 with no CTRL write, run one frame -> live_regs[7:0] is unchanged, frame_count = 1, irq = 0.
- Write reg0 = 0x55 and reg15 = 0xAA, write CTRL = 1, drive vcount to 480 at cycle 0:
  - live reg0 = 0x55 at cycle 2, reg15 = 0xAA at cycle 17.
  - irq = 1 at cycle 17; STATUS = 0b010.
- Auto mode on (CTRL = 2): change reg5 every frame -> live reg5 follows one frame later, with no CTRL bit0 writes.
- During COMMIT (cycle 3), write reg10 = 0x11 and CTRL = 1:
  - live reg10 = 0x11 this frame (copied at cycle 11).
  - The FSM ends in ARMED and commits again at the next vblank.
- Assert reset at cycle 5 of COMMIT -> all live_regs = RESET_VAL, state IDLE, irq = 0. Write 0x102 and 0x1FF, then read 0x1FF -> no state change, readdata = 0.
